// File: rtl/mdio_mon_pkg.sv
// Shared types and constants for the MDIO link monitor.
package mdio_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWReq,
    StWWait,
    StRReq,
    StRWait,
    StCheck,
    StNext,
    StWait
  } mon_state_e;

  localparam logic [1:0] SPD_10M  = 2'b00;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_1G   = 2'b10;
  localparam logic [1:0] SPD_UNK  = 2'b11;

  localparam logic [4:0]  BMCR_ADDR      = 5'd0;
  localparam int unsigned STATUS_REG_DEF = 17;

  localparam int unsigned LINK_BIT = 10;
  localparam int unsigned SPD_HI   = 15;
  localparam int unsigned SPD_LO   = 14;

  // Reserved PHY speed code 11 is reported as gigabit.
  function automatic logic [1:0] decode_speed(input logic [1:0] field);
    case (field)
      2'b00:   return SPD_10M;
      2'b01:   return SPD_100M;
      default: return SPD_1G;
    endcase
  endfunction

endpackage

// File: rtl/smi_read_write.sv
// Bit-level clause-22 MDIO read/write engine. done pulses for every write and
// for reads the PHY acknowledged by pulling the second turnaround bit low.
module smi_read_write #(
  parameter int unsigned REF_CLK = 50,
  parameter int unsigned MDC_CLK = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        done,
  output logic        mdc,
  inout  wire         mdio
);

  localparam int unsigned HalfRaw = (REF_CLK * 1000) / (2 * MDC_CLK);
  localparam int unsigned Half    = (HalfRaw == 0) ? 1 : HalfRaw;
  localparam logic [15:0] DivLast = 16'(Half - 1);

  logic        active_q, rd_q, ack_q, mdc_q, done_q;
  logic [5:0]  bit_q;
  logic [15:0] div_q;
  logic [63:0] sh_q;
  logic [15:0] rdata_q;
  logic        oe;

  // Release the line from the first turnaround bit of a read onwards.
  assign oe        = active_q && !(rd_q && (bit_q >= 6'd46));
  assign mdio      = oe ? sh_q[63] : 1'bz;
  assign mdc       = mdc_q;
  assign done      = done_q;
  assign read_data = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      rd_q     <= 1'b0;
      ack_q    <= 1'b0;
      mdc_q    <= 1'b0;
      done_q   <= 1'b0;
      bit_q    <= '0;
      div_q    <= '0;
      sh_q     <= '1;
      rdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (read_req || write_req) begin
          active_q <= 1'b1;
          rd_q     <= read_req;
          ack_q    <= 1'b0;
          mdc_q    <= 1'b0;
          bit_q    <= '0;
          div_q    <= '0;
          sh_q     <= {32'hFFFF_FFFF, 2'b01, (read_req ? 2'b10 : 2'b01), phy_addr, reg_addr,
                       2'b10, write_data};
        end
      end else if (div_q != DivLast) begin
        div_q <= div_q + 16'd1;
      end else begin
        div_q <= '0;
        if (!mdc_q) begin
          mdc_q <= 1'b1;
          if (rd_q && (bit_q == 6'd47)) ack_q <= ~mdio;
          if (rd_q && (bit_q >= 6'd48)) rdata_q <= {rdata_q[14:0], mdio};
        end else begin
          mdc_q <= 1'b0;
          if (bit_q == 6'd63) begin
            active_q <= 1'b0;
            done_q   <= ~rd_q | ack_q;
          end else begin
            bit_q <= bit_q + 6'd1;
            sh_q  <= {sh_q[62:0], 1'b1};
          end
        end
      end
    end
  end

endmodule

// File: rtl/mdio_link_monitor.sv
// Round-robin MDIO link/speed monitor for NUM_PHY PHYs on one shared bus,
// with start-up and link-loss autoneg restarts.
module mdio_link_monitor
  import mdio_mon_pkg::*;
#(
  parameter int unsigned REF_CLK        = 50,
  parameter int unsigned MDC_CLK        = 500,
  parameter int unsigned NUM_PHY        = 2,
  parameter int unsigned PHY_ADDR_BASE  = 1,
  parameter int unsigned STATUS_REG     = STATUS_REG_DEF,
  parameter int unsigned POLL_CYCLES    = 50_000_000,
  parameter bit          INIT_RESTART   = 1'b1,
  parameter logic [15:0] RESTART_DATA   = 16'h1340,
  parameter int unsigned RESTART_POLLS  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mdc,
  inout  wire                    mdio,
  input  logic                   force_poll,
  output logic [NUM_PHY-1:0]     link,
  output logic [2*NUM_PHY-1:0]   speed,
  output logic [NUM_PHY-1:0]     smi_err,
  output logic                   change,
  output logic                   busy
);

  localparam int unsigned CW      = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
  localparam logic [CW-1:0] ChLast = CW'(NUM_PHY - 1);
  localparam logic [31:0] PollLast = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] ToLast   = 32'(TIMEOUT_CYCLES - 1);

  mon_state_e             state_q;
  logic [CW-1:0]          ch_q;
  logic                   init_q;
  logic [31:0]            timer_q, to_q;
  logic [15:0]            rdata_q;
  logic [NUM_PHY-1:0]     link_q, smi_err_q;
  logic [2*NUM_PHY-1:0]   speed_q;
  logic                   change_q;
  logic [7:0]             unlink_q [NUM_PHY];

  logic        smi_done;
  logic [15:0] smi_rdata;
  logic        read_req, write_req;
  logic [4:0]  phy_addr, reg_addr;

  logic [CW:0] sidx;
  logic [2:0]  cur_state;
  logic [1:0]  rd_spd;
  logic [7:0]  cnt_inc;
  logic        restart_hit;
  logic        unused_rdata;

  assign write_req    = (state_q == StWReq);
  assign read_req     = (state_q == StRReq);
  assign phy_addr     = 5'(PHY_ADDR_BASE) + 5'(ch_q);
  assign reg_addr     = write_req ? BMCR_ADDR : 5'(STATUS_REG);
  assign unused_rdata = ^rdata_q;

  assign link    = link_q;
  assign speed   = speed_q;
  assign smi_err = smi_err_q;
  assign change  = change_q;
  assign busy    = !(state_q inside {StIdle, StWait});

  always_comb begin
    sidx        = {ch_q, 1'b0};
    cur_state   = {link_q[ch_q], speed_q[sidx +: 2]};
    rd_spd      = decode_speed(rdata_q[SPD_HI:SPD_LO]);
    cnt_inc     = (unlink_q[ch_q] == 8'hFF) ? 8'hFF : unlink_q[ch_q] + 8'd1;
    restart_hit = (RESTART_POLLS != 0) && (32'(cnt_inc) == RESTART_POLLS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      init_q    <= 1'b0;
      timer_q   <= '0;
      to_q      <= '0;
      rdata_q   <= '0;
      link_q    <= '0;
      speed_q   <= {NUM_PHY{SPD_UNK}};
      smi_err_q <= '0;
      change_q  <= 1'b0;
      for (int i = 0; i < NUM_PHY; i++) unlink_q[i] <= '0;
    end else begin
      change_q <= 1'b0;
      case (state_q)
        StIdle: begin
          ch_q <= '0;
          if (INIT_RESTART) begin
            init_q  <= 1'b1;
            state_q <= StWReq;
          end else begin
            state_q <= StRReq;
          end
        end
        StWReq: begin
          to_q    <= '0;
          state_q <= StWWait;
        end
        StWWait: begin
          if (smi_done || (to_q == ToLast)) begin
            if (!smi_done) smi_err_q[ch_q] <= 1'b1;
            if (init_q) begin
              if (ch_q == ChLast) begin
                ch_q    <= '0;
                init_q  <= 1'b0;
                state_q <= StRReq;
              end else begin
                ch_q    <= ch_q + CW'(1);
                state_q <= StWReq;
              end
            end else begin
              state_q <= StNext;
            end
          end else begin
            to_q <= to_q + 32'd1;
          end
        end
        StRReq: begin
          to_q    <= '0;
          state_q <= StRWait;
        end
        StRWait: begin
          if (smi_done) begin
            rdata_q          <= smi_rdata;
            smi_err_q[ch_q]  <= 1'b0;
            state_q          <= StCheck;
          end else if (to_q == ToLast) begin
            smi_err_q[ch_q]   <= 1'b1;
            link_q[ch_q]      <= 1'b0;
            speed_q[sidx +: 2] <= SPD_UNK;
            change_q          <= (cur_state != {1'b0, SPD_UNK});
            state_q           <= StNext;
          end else begin
            to_q <= to_q + 32'd1;
          end
        end
        StCheck: begin
          if (rdata_q[LINK_BIT]) begin
            link_q[ch_q]       <= 1'b1;
            speed_q[sidx +: 2] <= rd_spd;
            unlink_q[ch_q]     <= '0;
            change_q           <= (cur_state != {1'b1, rd_spd});
            state_q            <= StNext;
          end else begin
            // Speed is left as-is, so only a falling link counts as a change.
            link_q[ch_q] <= 1'b0;
            change_q     <= cur_state[2];
            if (restart_hit) begin
              unlink_q[ch_q] <= '0;
              state_q        <= StWReq;
            end else begin
              unlink_q[ch_q] <= cnt_inc;
              state_q        <= StNext;
            end
          end
        end
        StNext: begin
          if (ch_q == ChLast) begin
            ch_q    <= '0;
            timer_q <= '0;
            state_q <= StWait;
          end else begin
            ch_q    <= ch_q + CW'(1);
            state_q <= StRReq;
          end
        end
        StWait: begin
          if ((timer_q == PollLast) || force_poll) begin
            timer_q <= '0;
            state_q <= StRReq;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  smi_read_write #(
    .REF_CLK (REF_CLK),
    .MDC_CLK (MDC_CLK)
  ) u_smi (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_req   (read_req),
    .write_req  (write_req),
    .phy_addr   (phy_addr),
    .reg_addr   (reg_addr),
    .write_data (RESTART_DATA),
    .read_data  (smi_rdata),
    .done       (smi_done),
    .mdc        (mdc),
    .mdio       (mdio)
  );

endmodule
